bitserial_mac_sequencer: RTL
============================

# bitserial_mac_sequencer

- Controller that turns a bit-serial multiplier into a dot-product MAC engine.
- Accepts a command giving a vector length, then pulls unsigned operand pairs over a valid/ready stream.
- For each pair it runs one multiply on the bitserial_multiplier: start pulse plus LSB-first serial multiplier bits. It then waits for `done` and accumulates the product.
- Sits between the operand buffer/DMA front end and the multiplier. It returns the final sum over a valid/ready result port.

## Interface
Parameters:
- A_WIDTH, 4, multiplicand width (matches multiplier MULTIPLICAND_WIDTH)
- B_WIDTH, 4, multiplier width (matches MULTIPLIER_WIDTH); number of serial bits
- ACC_WIDTH, 16, accumulator/result width; must be ≥ A_WIDTH+B_WIDTH
- LEN_WIDTH, 8, width of vector-length field
- TIMEOUT_CYCLES, 64, done-wait limit (used only with the timeout macro)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_start  in  1  begin a dot product; sampled only in IDLE
- cmd_len  in  LEN_WIDTH  number of operand pairs; captured with cmd_start
- cmd_busy  out  1  high in every state except IDLE
- op_valid  in  1  operand pair available
- op_ready  out  1  high only in FETCH
- op_a  in  A_WIDTH  multiplicand
- op_b  in  B_WIDTH  multiplier
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_multiplicand  out  A_WIDTH  held stable from START until done
- mul_multiplier  out  B_WIDTH  parallel copy of op_b, held stable likewise
- mul_serial_bit  out  1  serial multiplier bit, LSB first
- mul_product  in  A_WIDTH+B_WIDTH  multiplier result
- mul_done  in  1  multiplier completion
- res_valid  out  1  result available
- res_ready  in  1  result consumer accepts
- res_data  out  ACC_WIDTH  accumulated sum
- res_overflow  out  1  sticky: accumulator wrapped during this command
- res_error  out  1  multiply aborted by timeout

## Operation
States:
- IDLE
  - cmd_start=1: capture cmd_len, clear acc, count and overflow.
  - Go to FETCH, or to RESULT if cmd_len=0.
- FETCH
  - op_ready=1.
  - On op_valid: register op_a/op_b and go to START.
- START
  - mul_start=1, mul_serial_bit=op_b[0].
  - Load the serializer shift register.
  - If B_WIDTH=1 go to WAIT, else go to SHIFT.
- SHIFT
  - Drive op_b[k] for k=1..B_WIDTH-1, one bit per cycle.
  - Go to WAIT after the last bit.
- WAIT
  - mul_serial_bit=0.
  - On mul_done=1: acc ← acc + mul_product (zero-extended), count++.
  - Then go to RESULT if count = len, else FETCH.
- RESULT
  - res_valid=1, with res_data/res_overflow/res_error stable.
  - On res_ready go to IDLE.

Rules:
- Arithmetic is unsigned, modulo 2^ACC_WIDTH. A carry out of the accumulator sets res_overflow, which is sticky until the next cmd_start.
- cmd_start is ignored while cmd_busy=1.
- mul_done is only honoured in WAIT; a mul_done seen in any other state is ignored.
- Reset (any state): state=IDLE and all outputs 0, including res_valid, op_ready, mul_start, mul_serial_bit, cmd_busy and the flags. acc/count/len are cleared. The multiplier shares rst, so the pair restarts cleanly.

## Timing
- A per-pair cycle starts at the op handshake in cycle T:
  - START in T+1, carrying bit 0.
  - Bit k goes out in T+1+k.
  - WAIT begins at T+B_WIDTH+1.
- Accumulation is registered in the cycle mul_done is seen; the next FETCH follows one cycle later.
- Back-to-back pairs: the earliest next op_ready is the cycle after done.
- res_valid rises the cycle after the final done, or the cycle after cmd_start when cmd_len=0.
- res_valid and res_data are held stable under backpressure.
- cmd_busy drops the cycle after the res handshake.

## Configuration
- BSMAC_SEQ_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If mul_done is not seen within TIMEOUT_CYCLES cycles: set res_error=1 and go to RESULT with acc unchanged. Remaining pairs are not fetched.
- Undefined:
  - No counter; WAIT blocks until mul_done.
  - res_error is tied 0.

## Structure
- Shared package bsmac_pkg holds:
  - the state encoding (IDLE, FETCH, START, SHIFT, WAIT, RESULT);
  - default width constants;
  - the timeout default.
- One sub-module: bsmac_bit_serializer. It is a loadable LSB-first shift register with a bit-index counter and a `last` flag.
- The FSM, accumulator and handshakes stay in the top module.

## Test plan
- len=1, (a=2,b=6) → one mul_start; serial bits 0,1,1,0 in consecutive cycles; res_data=12, overflow=0.
- len=3, pairs (F,F),(2,6),(1,1) with op_valid gaps of 3 cycles → res_data=0xEE (238); exactly 3 mul_start pulses.
- cmd_len=0 → res_valid the cycle after cmd_start, res_data=0, no mul_start.
- ACC_WIDTH=8, len=2, (F,F),(F,F) → res_data=0xC2, res_overflow=1.
- res_ready held low 5 cycles → res_valid and res_data stable; a cmd_start pulse during this window is ignored.
- Reset:
  - Assert rst during SHIFT → next cycle all outputs 0 and state IDLE; a new command then gives a correct result.
- Timeout (with BSMAC_SEQ_TIMEOUT_EN):
  - Hold mul_done low → after 64 WAIT cycles res_valid=1, res_error=1.

Source files
------------

// File: rtl/bsmac_pkg.sv
// bsmac_pkg: shared definitions for the bit-serial MAC sequencer.
//   - state_e      : controller state encoding
//   - *_DEF        : default widths used by the top-level parameters
//   - TIMEOUT_DEF  : default done-wait limit for the optional timeout
package bsmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_START  = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RESULT = 3'd5
  } state_e;

  localparam int unsigned A_WIDTH_DEF   = 4;
  localparam int unsigned B_WIDTH_DEF   = 4;
  localparam int unsigned ACC_WIDTH_DEF = 16;
  localparam int unsigned LEN_WIDTH_DEF = 8;
  localparam int unsigned TIMEOUT_DEF   = 64;

endpackage

// File: rtl/bsmac_bit_serializer.sv
// bsmac_bit_serializer: loadable LSB-first shift register.
// Bit 0 of the loaded word is sent directly by the controller during the
// load cycle, so the register keeps only bits 1..WIDTH-1.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (index counter only)
//   load_i     : capture data_i (bit 0 already sent by the caller)
//   data_i     : word to serialize
//   shift_i    : advance one bit
//   bit_o      : current serial bit (valid after load, before each shift)
//   last_o     : bit_o is the final bit of the word
module bsmac_bit_serializer
  import bsmac_pkg::*;
#(
  parameter int unsigned WIDTH = B_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  output logic             bit_o,
  output logic             last_o
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] sh_q;
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else if (load_i) begin
      idx_q <= IDX_W'(1);
    end else if (shift_i) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  // Data path carries no reset; its output is only selected while shifting.
  always_ff @(posedge clk) begin
    if (load_i) begin
      sh_q <= data_i >> 1;
    end else if (shift_i) begin
      sh_q <= sh_q >> 1;
    end
  end

  assign bit_o  = sh_q[0];
  assign last_o = (idx_q == IDX_W'(WIDTH - 1));

endmodule

// File: rtl/bitserial_mac_sequencer.sv
// bitserial_mac_sequencer: drives a bit-serial multiplier as a dot-product
// MAC. Takes a length command, fetches unsigned (a,b) pairs, runs one serial
// multiply per pair and accumulates products modulo 2^ACC_WIDTH.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_start/cmd_len        : command (sampled in IDLE), cmd_busy status
//   op_valid/op_ready/op_a/b : operand pair stream
//   mul_*                    : multiplier control, serial bit, product/done
//   res_valid/res_ready      : result handshake
//   res_data/overflow/error  : sum, sticky carry-out flag, timeout flag
// Optional feature: define BSMAC_SEQ_TIMEOUT_EN to abort a multiply that has
// not signalled done within TIMEOUT_CYCLES WAIT cycles (res_error=1).
module bitserial_mac_sequencer
  import bsmac_pkg::*;
#(
  parameter int unsigned A_WIDTH        = A_WIDTH_DEF,
  parameter int unsigned B_WIDTH        = B_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH      = ACC_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH      = LEN_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_start,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  output logic                       cmd_busy,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [A_WIDTH-1:0]         op_a,
  input  logic [B_WIDTH-1:0]         op_b,
  output logic                       mul_start,
  output logic [A_WIDTH-1:0]         mul_multiplicand,
  output logic [B_WIDTH-1:0]         mul_multiplier,
  output logic                       mul_serial_bit,
  input  logic [A_WIDTH+B_WIDTH-1:0] mul_product,
  input  logic                       mul_done,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ACC_WIDTH-1:0]       res_data,
  output logic                       res_overflow,
  output logic                       res_error
);

  localparam int unsigned SUM_W = ACC_WIDTH + 1;

  if (ACC_WIDTH < A_WIDTH + B_WIDTH) begin : g_bad_acc
    $error("ACC_WIDTH must be at least A_WIDTH+B_WIDTH");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // Unsigned add with the carry-out kept as the top bit.
  function automatic logic [SUM_W-1:0] acc_add(input logic [ACC_WIDTH-1:0]       acc,
                                               input logic [A_WIDTH+B_WIDTH-1:0] prod);
    return {1'b0, acc} + SUM_W'(prod);
  endfunction

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, cnt_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic                   ovf_q;
  logic [A_WIDTH-1:0]     a_q;
  logic [B_WIDTH-1:0]     b_q;
  logic [SUM_W-1:0]       sum;
  logic                   cap_cmd, cap_op, acc_en, ser_load, ser_shift;
  logic                   ser_bit, ser_last;
  logic                   set_err;

  assign sum = acc_add(acc_q, mul_product);

  bsmac_bit_serializer #(.WIDTH(B_WIDTH)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ser_load),
    .data_i  (b_q),
    .shift_i (ser_shift),
    .bit_o   (ser_bit),
    .last_o  (ser_last)
  );

`ifdef BSMAC_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
  logic             tmo_hit;

  // Counts cycles spent in WAIT; hit marks the last allowed cycle.
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= (state_q == ST_WAIT) ? tmo_q + TMO_W'(1) : '0;
      if (cap_cmd)      err_q <= 1'b0;
      else if (set_err) err_q <= 1'b1;
    end
  end
  assign res_error = err_q;
`else
  assign res_error = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cap_cmd   = 1'b0;
    cap_op    = 1'b0;
    acc_en    = 1'b0;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    set_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          cap_cmd = 1'b1;
          state_d = (cmd_len == '0) ? ST_RESULT : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (op_valid) begin
          cap_op  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        ser_load = 1'b1;
        state_d  = (B_WIDTH == 1) ? ST_WAIT : ST_SHIFT;
      end
      ST_SHIFT: begin
        ser_shift = 1'b1;
        if (ser_last) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_done) begin
          acc_en  = 1'b1;
          state_d = (cnt_q + LEN_WIDTH'(1) == len_q) ? ST_RESULT : ST_FETCH;
        end
`ifdef BSMAC_SEQ_TIMEOUT_EN
        else if (tmo_hit) begin
          set_err = 1'b1;
          state_d = ST_RESULT;
        end
`endif
      end
      ST_RESULT: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      if (cap_cmd) begin
        len_q <= cmd_len;
        cnt_q <= '0;
        acc_q <= '0;
        ovf_q <= 1'b0;
      end
      // Operands stay registered until the next fetch so the multiplier
      // sees them stable through done.
      if (cap_op) begin
        a_q <= op_a;
        b_q <= op_b;
      end
      if (acc_en) begin
        acc_q <= sum[ACC_WIDTH-1:0];
        ovf_q <= ovf_q | sum[ACC_WIDTH];
        cnt_q <= cnt_q + LEN_WIDTH'(1);
      end
    end
  end

  assign cmd_busy         = (state_q != ST_IDLE);
  assign op_ready         = (state_q == ST_FETCH);
  assign mul_start        = (state_q == ST_START);
  assign mul_multiplicand = a_q;
  assign mul_multiplier   = b_q;
  // Bit 0 goes out with the start pulse; later bits come from the serializer.
  assign mul_serial_bit   = (state_q == ST_START) ? b_q[0] :
                            (state_q == ST_SHIFT) ? ser_bit : 1'b0;
  assign res_valid        = (state_q == ST_RESULT);
  assign res_data         = acc_q;
  assign res_overflow     = ovf_q;

endmodule
